// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encodings for the countdown controller
package countdown_pkg;

    localparam int CD_STATE_W = 2;

    typedef enum logic [CD_STATE_W-1:0] {
        CD_IDLE  = 2'd0,
        CD_RUN   = 2'd1,
        CD_PAUSE = 2'd2,
        CD_DONE  = 2'd3
    } cd_state_t;

endpackage

// File: rtl/countdown_prescaler.sv
// rtl/countdown_prescaler.sv - modulo-TICK_DIV tick prescaler with enable and clear
module countdown_prescaler #(
    parameter int TICK_DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase;

    assign wrap = en && (phase == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= wrap ? '0 : phase + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - load/start/pause countdown sequencer with expiry pulse and done blink
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 32,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load,
    input  logic [CNT_W-1:0]      load_val,
    output logic [CNT_W-1:0]      digits,
    output logic [CD_STATE_W-1:0] state,
    output logic                  done_pulse,
    output logic                  blank
);

    cd_state_t        st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             blank_nxt;
    logic             done_nxt;
    logic             load_act;
    logic             pre_en;
    logic             wrap;

    // The prescaler also advances on the edge that samples pause, so RUN
    // cycles between decrements always total TICK_DIV across a pause.
    assign pre_en = (st == CD_RUN) || (st == CD_DONE);

    countdown_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (pre_en),
        .clr  (load_act),
        .wrap (wrap)
    );

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        blank_nxt = blank;
        done_nxt  = 1'b0;
        load_act  = 1'b0;
        case (st)
            CD_IDLE: begin
                if (load) begin
                    load_act = 1'b1;
                    cnt_nxt  = load_val;
                end else if (start && (cnt != '0)) begin
                    st_nxt = CD_RUN;
                end
            end
            CD_RUN: begin
                if (wrap) begin
                    cnt_nxt = cnt - 1'b1;
                end
                // Expiry wins over a same-cycle pause so PAUSE never holds a zero count.
                if (wrap && (cnt == CNT_W'(1))) begin
                    st_nxt   = CD_DONE;
                    done_nxt = 1'b1;
                end else if (pause) begin
                    st_nxt = CD_PAUSE;
                end
            end
            CD_PAUSE: begin
                if (load) begin
                    load_act = 1'b1;
                    cnt_nxt  = load_val;
                    st_nxt   = CD_IDLE;
                end else if (start) begin
                    st_nxt = CD_RUN;
                end
            end
            CD_DONE: begin
                if (load) begin
                    load_act  = 1'b1;
                    cnt_nxt   = load_val;
                    blank_nxt = 1'b0;
                    st_nxt    = CD_IDLE;
                end else if (wrap) begin
                    blank_nxt = ~blank;
                end
            end
            default: st_nxt = CD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= CD_IDLE;
            cnt        <= '0;
            blank      <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            st         <= st_nxt;
            cnt        <= cnt_nxt;
            blank      <= blank_nxt;
            done_pulse <= done_nxt;
        end
    end

    assign digits = cnt;
    assign state  = st;

endmodule
